mcpu_ctrl_fsm: RTL and testbench
================================

# mcpu_ctrl_fsm

Multicycle control unit for the MCPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives every select and write-enable consumed by the datapath multiplexers: RegDst, ALUSrc, ALUSrc0, ToReg and IorD. It also drives the PC, IR, register-file and memory write strobes, the ALU operation, the extender mode and the next-PC selection. It sits directly upstream of the mux stage and is the only sequential control element in the core.

## Interface
- No parameters. All encodings are fixed by ctrl_encode_def.v:
  - RD_RT=00, RD_RD=01, RD_RA=10.
  - ALUSRC_REG=00, ALUSRC_IMM=01, ALUSRC_SHA=10, ALUSRC_ZERO=11.
  - DM2REG=00, ALU2REG=01, NPC2REG=10.
- clk  in  1  single clock; all state changes occur on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Op  in  6  IR[31:26]; valid from the cycle after FETCH.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag; sampled only in S_BR.
- PCWrite  out  1  PC load strobe.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- IRWrite  out  1  instruction register load strobe.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write strobe.
- RegDst  out  2  destination register select.
- ALUSrc  out  2  ALU B operand select.
- ALUSrc0  out  1  ALU A operand select: 0 = RD1, 1 = RD2 (used by shifts).
- ToReg  out  2  register write-data select.
- ALUOp  out  4  ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6, LUI=7.
- EXTOp  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- NPCOp  out  2  next-PC source: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = RD1 (jr).
- State  out  4  current state, for debug.
- Illegal  out  1  one-cycle pulse on an unsupported opcode or funct.

## Operation
- Supported instructions:
  - R-type: add, sub, and, or, slt, sll, srl, jr.
  - I-type: addi (001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), bne (000101).
  - J-type: j (000010), jal (000011).
- State encoding: S_FETCH=0, S_DCODE=1, S_MADR=2, S_MRD=3, S_MWB=4, S_MWR=5, S_EXE=6, S_ALUWB=7, S_BR=8, S_JMP=9. Encodings 10–15 are unreachable and return to S_FETCH.
- Outputs are Moore-style: decoded combinationally from State plus the held Op/Funct. The IR is stable from S_DCODE onward.
- Every output not listed for a state is 0.
- S_FETCH:
  - Outputs: IorD=0, IRWrite=1, PCWrite=1, NPCOp=00.
  - Next state: S_DCODE.
- S_DCODE, no strobes. Next state:
  - lw/sw → S_MADR.
  - R-type except jr, and addi/ori/lui → S_EXE.
  - beq/bne → S_BR.
  - j, jal, jr → S_JMP.
  - Anything else → S_FETCH with Illegal=1.
- S_MADR:
  - Outputs: ALUSrc=IMM, EXTOp=1, ALUOp=ADD.
  - Next state: S_MRD for lw, S_MWR for sw.
- S_MRD:
  - Outputs: IorD=1, plus the S_MADR ALU controls held so the address stays stable.
  - Next state: S_MWB.
- S_MWB:
  - Outputs: RegWrite=1, RegDst=RD_RT, ToReg=DM2REG.
  - Next state: S_FETCH.
- S_MWR:
  - Outputs: IorD=1, MemWrite=1, with the S_MADR ALU controls held.
  - Next state: S_FETCH.
- S_EXE, by instruction:
  - R-type add/sub/and/or/slt: ALUSrc=REG, ALUOp per funct.
  - sll/srl: ALUSrc0=1, ALUSrc=SHA.
  - addi: ALUSrc=IMM, EXTOp=1, ALUOp=ADD.
  - ori: ALUSrc=IMM, EXTOp=0, ALUOp=OR.
  - lui: ALUSrc=IMM, ALUOp=LUI.
  - Next state: S_ALUWB.
- S_ALUWB:
  - Outputs: the S_EXE controls held, plus RegWrite=1 and ToReg=ALU2REG.
  - RegDst: RD_RD for R-type, RD_RT for I-type.
  - Next state: S_FETCH.
- S_BR:
  - Outputs: ALUSrc=REG, ALUOp=SUB, NPCOp=01.
  - PCWrite = Zero for beq, ~Zero for bne.
  - Next state: S_FETCH.
- S_JMP:
  - Outputs: PCWrite=1.
  - NPCOp: 10 for j/jal, 11 for jr.
  - jal additionally asserts RegWrite=1, RegDst=RD_RA, ToReg=NPC2REG. The PC already holds PC+4 from FETCH.
  - Next state: S_FETCH.
- Funct decoding for R-type:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000010 srl, 001000 jr.
  - Any other funct is illegal.

## Timing
- Reset:
  - rst high at a rising edge → State=S_FETCH on that edge, regardless of the current state.
  - While rst is high, all strobes (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0 and Illegal=0.
  - Selects take their S_FETCH values.
- First fetch: on the first edge after rst falls.
- CPI:
  - lw 5.
  - R-type ALU ops, addi, ori, lui, sw: 4.
  - beq, bne, j, jal, jr: 3.
  - Illegal instruction: 2.
- Exactly one write strobe of RegWrite/MemWrite per instruction at most; never both in the same cycle.
- PCWrite:
  - Asserted exactly once in FETCH.
  - At most once more, in S_BR or S_JMP.
- Illegal: high only during the S_DCODE cycle of the offending instruction.
- Reset during S_MWR or S_MWB: the strobe is suppressed in that cycle. The partial instruction is abandoned.

## Test plan
- Reset: rst=1 for 2 cycles starting in S_MWR (State=5) → MemWrite=0 during reset; State=0 after the edge. The next cycle shows IRWrite=1, PCWrite=1.
- lw (Op=100011): State sequence 0,1,2,3,4,0 → IorD=1 in states 3 and 2→3 hold; RegWrite=1 only in state 4 with RegDst=00, ToReg=00.
- sll (Op=0, Funct=000000): sequence 0,1,6,7,0 → ALUSrc0=1, ALUSrc=10, ALUOp=5 in states 6/7; RegDst=01 at writeback.
- Branches:
  - beq with Zero=1 → PCWrite=1, NPCOp=01 in state 8.
  - bne with Zero=1 → PCWrite=0.
- jal (Op=000011): sequence 0,1,9,0 → in state 9: PCWrite=1, NPCOp=10, RegWrite=1, RegDst=10, ToReg=10.
- Illegal:
  - Op=111111 → Illegal=1 for one cycle in state 1, no strobes, back to state 0.
  - Funct=111111 with Op=0 → same behaviour.

Source files
------------

// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm: multicycle control unit for the MCPU datapath.
// Steps each instruction through fetch / decode / execute / memory / writeback
// and drives every datapath select and write strobe from the current state
// plus the opcode and funct fields held in the IR.
module mcpu_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrc,
    output logic       ALUSrc0,
    output logic [1:0] ToReg,
    output logic [3:0] ALUOp,
    output logic       EXTOp,
    output logic [1:0] NPCOp,
    output logic [3:0] State,
    output logic       Illegal
);

    // Datapath select encodings shared with the mux stage.
    localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
    localparam logic [1:0] ALUSRC_REG = 2'b00, ALUSRC_IMM = 2'b01, ALUSRC_SHA = 2'b10;
    localparam logic [1:0] DM2REG = 2'b00, ALU2REG = 2'b01, NPC2REG = 2'b10;
    localparam logic [1:0] NPC_PLUS4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JR = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_LUI = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010, FN_JR = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCODE = 4'd1,
        S_MADR  = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_EXE   = 4'd6,
        S_ALUWB = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9
    } state_t;

    state_t state_q, state_d;

    // Instruction class and execute-stage ALU controls decoded from Op/Funct.
    logic       is_rtype;
    logic       dec_mem, dec_exe, dec_br, dec_jmp, dec_legal;
    logic [1:0] exe_alusrc;
    logic       exe_alusrc0;
    logic [3:0] exe_aluop;
    logic       exe_extop;

    // Instruction decode: classify the opcode and select the execute controls.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        is_rtype    = (Op == OP_RTYPE);
        dec_mem     = 1'b0;
        dec_exe     = 1'b0;
        dec_br      = 1'b0;
        dec_jmp     = 1'b0;
        exe_alusrc  = ALUSRC_REG;
        exe_alusrc0 = 1'b0;
        exe_aluop   = ALU_ADD;
        exe_extop   = 1'b0;
        case (Op)
            OP_RTYPE: begin
                case (Funct)
                    FN_ADD: begin dec_exe = 1'b1; exe_aluop = ALU_ADD; end
                    FN_SUB: begin dec_exe = 1'b1; exe_aluop = ALU_SUB; end
                    FN_AND: begin dec_exe = 1'b1; exe_aluop = ALU_AND; end
                    FN_OR:  begin dec_exe = 1'b1; exe_aluop = ALU_OR;  end
                    FN_SLT: begin dec_exe = 1'b1; exe_aluop = ALU_SLT; end
                    FN_SLL: begin
                        dec_exe = 1'b1; exe_alusrc0 = 1'b1;
                        exe_alusrc = ALUSRC_SHA; exe_aluop = ALU_SLL;
                    end
                    FN_SRL: begin
                        dec_exe = 1'b1; exe_alusrc0 = 1'b1;
                        exe_alusrc = ALUSRC_SHA; exe_aluop = ALU_SRL;
                    end
                    FN_JR:   dec_jmp = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_exe = 1'b1; exe_alusrc = ALUSRC_IMM; exe_extop = 1'b1; exe_aluop = ALU_ADD;
            end
            OP_ORI: begin
                dec_exe = 1'b1; exe_alusrc = ALUSRC_IMM; exe_extop = 1'b0; exe_aluop = ALU_OR;
            end
            OP_LUI: begin
                dec_exe = 1'b1; exe_alusrc = ALUSRC_IMM; exe_aluop = ALU_LUI;
            end
            OP_LW, OP_SW:   dec_mem = 1'b1;
            OP_BEQ, OP_BNE: dec_br  = 1'b1;
            OP_J, OP_JAL:   dec_jmp = 1'b1;
            default: ;
        endcase
        dec_legal = dec_mem | dec_exe | dec_br | dec_jmp;
    end

    // Next-state selection; unreachable encodings fall back to fetch.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DCODE;
            S_DCODE: begin
                if (dec_mem)      state_d = S_MADR;
                else if (dec_exe) state_d = S_EXE;
                else if (dec_br)  state_d = S_BR;
                else if (dec_jmp) state_d = S_JMP;
                else              state_d = S_FETCH;
            end
            S_MADR: begin
                if (Op == OP_LW)      state_d = S_MRD;
                else if (Op == OP_SW) state_d = S_MWR;
                else                  state_d = S_FETCH;
            end
            S_MRD:   state_d = S_MWB;
            S_EXE:   state_d = S_ALUWB;
            default: state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset to fetch.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Moore output decode; reset holds every strobe low with fetch-state selects.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = RD_RT;
        ALUSrc   = ALUSRC_REG;
        ALUSrc0  = 1'b0;
        ToReg    = DM2REG;
        ALUOp    = ALU_ADD;
        EXTOp    = 1'b0;
        NPCOp    = NPC_PLUS4;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                S_MADR: begin
                    ALUSrc = ALUSRC_IMM; EXTOp = 1'b1; ALUOp = ALU_ADD;
                end
                S_MRD: begin
                    IorD = 1'b1;
                    ALUSrc = ALUSRC_IMM; EXTOp = 1'b1; ALUOp = ALU_ADD;
                end
                S_MWB: begin
                    RegWrite = 1'b1; RegDst = RD_RT; ToReg = DM2REG;
                end
                S_MWR: begin
                    IorD = 1'b1; MemWrite = 1'b1;
                    ALUSrc = ALUSRC_IMM; EXTOp = 1'b1; ALUOp = ALU_ADD;
                end
                S_EXE: begin
                    ALUSrc = exe_alusrc; ALUSrc0 = exe_alusrc0;
                    ALUOp = exe_aluop; EXTOp = exe_extop;
                end
                S_ALUWB: begin
                    ALUSrc = exe_alusrc; ALUSrc0 = exe_alusrc0;
                    ALUOp = exe_aluop; EXTOp = exe_extop;
                    RegWrite = 1'b1; ToReg = ALU2REG;
                    RegDst = is_rtype ? RD_RD : RD_RT;
                end
                S_BR: begin
                    ALUSrc = ALUSRC_REG; ALUOp = ALU_SUB; NPCOp = NPC_BRANCH;
                    PCWrite = (Op == OP_BEQ) ? Zero : ~Zero;
                end
                S_JMP: begin
                    PCWrite = 1'b1;
                    NPCOp = (is_rtype && Funct == FN_JR) ? NPC_JR : NPC_JUMP;
                    if (Op == OP_JAL) begin
                        RegWrite = 1'b1; RegDst = RD_RA; ToReg = NPC2REG;
                    end
                end
                default: ;
            endcase
        end
    end

    assign State   = state_q;
    assign Illegal = !rst && (state_q == S_DCODE) && !dec_legal;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// tb_mcpu_ctrl_fsm: directed vector table for mcpu_ctrl_fsm plus hand-written
// sequences for reset mid-instruction and per-instruction cycle/strobe counts.
module tb_mcpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       PCWrite, IorD, IRWrite, MemWrite, RegWrite;
    logic [1:0] RegDst, ALUSrc, ToReg, NPCOp;
    logic       ALUSrc0, EXTOp, Illegal;
    logic [3:0] ALUOp, State;

    typedef struct packed {
        logic       pcw, iord, irw, memw, regw;
        logic [1:0] regdst, alusrc;
        logic       alusrc0;
        logic [1:0] toreg;
        logic [3:0] aluop;
        logic       extop;
        logic [1:0] npcop;
        logic       ill;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op, funct;
        logic       zero;
        logic [3:0] st;
        outs_t      o;
    } vec_t;

    vec_t  vecs[$];
    outs_t act;
    int    total = 0;
    int    bad   = 0;

    mcpu_ctrl_fsm dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUSrc0(ALUSrc0),
        .ToReg(ToReg), .ALUOp(ALUOp), .EXTOp(EXTOp), .NPCOp(NPCOp),
        .State(State), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, IorD, IRWrite, MemWrite, RegWrite, RegDst, ALUSrc,
                  ALUSrc0, ToReg, ALUOp, EXTOp, NPCOp, Illegal};

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    function automatic outs_t mk(input logic pcw, iord, irw, memw, regw,
                                 input logic [1:0] rd, as, input logic as0,
                                 input logic [1:0] tr, input logic [3:0] aop,
                                 input logic ext, input logic [1:0] npc, input logic ill);
        return {pcw, iord, irw, memw, regw, rd, as, as0, tr, aop, ext, npc, ill};
    endfunction

    task automatic add(input string n, input logic r, input logic [5:0] op, fn,
                       input logic z, input logic [3:0] st, input outs_t o);
        vec_t v;
        v.name = n; v.rst = r; v.op = op; v.funct = fn; v.zero = z; v.st = st; v.o = o;
        vecs.push_back(v);
    endtask

    // Runs one instruction from fetch back to fetch, counting cycles and strobes.
    task automatic run_instr(input string n, input logic [5:0] op, fn,
                             input int exp_cpi, exp_wr, exp_pcw);
        int cyc = 0;
        int wr  = 0;
        int pcw = 0;
        Op = op; Funct = fn; Zero = 1'b1;
        do begin
            @(negedge clk);
            wr  += int'(RegWrite) + int'(MemWrite);
            pcw += int'(PCWrite);
            cyc++;
            @(posedge clk); #1;
        end while (State != 4'd0 && cyc < 20);
        check({n, " cpi"}, cyc, exp_cpi);
        check({n, " wr"}, wr, exp_wr);
        check({n, " pcw"}, pcw, exp_pcw);
    endtask

    initial begin
        outs_t f_o, z_o, madr_o, mrd_o, ex_o, wb_o;
        f_o    = mk(1,0,1,0,0, 2'b00,2'b00,0,2'b00,4'd0,0,2'b00,0);
        z_o    = '0;
        madr_o = mk(0,0,0,0,0, 2'b00,2'b01,0,2'b00,4'd0,1,2'b00,0);
        mrd_o  = mk(0,1,0,0,0, 2'b00,2'b01,0,2'b00,4'd0,1,2'b00,0);

        add("rst", 1, 6'h00, 6'h00, 0, 4'd0, z_o);
        // lw
        add("lw f",    0, 6'h23, 6'h00, 0, 4'd0, f_o);
        add("lw d",    0, 6'h23, 6'h00, 0, 4'd1, z_o);
        add("lw madr", 0, 6'h23, 6'h00, 0, 4'd2, madr_o);
        add("lw mrd",  0, 6'h23, 6'h00, 0, 4'd3, mrd_o);
        add("lw mwb",  0, 6'h23, 6'h00, 0, 4'd4, mk(0,0,0,0,1, 2'b00,2'b00,0,2'b00,4'd0,0,2'b00,0));
        // sll
        ex_o = mk(0,0,0,0,0, 2'b00,2'b10,1,2'b00,4'd5,0,2'b00,0);
        wb_o = mk(0,0,0,0,1, 2'b01,2'b10,1,2'b01,4'd5,0,2'b00,0);
        add("sll f",  0, 6'h00, 6'h00, 0, 4'd0, f_o);
        add("sll d",  0, 6'h00, 6'h00, 0, 4'd1, z_o);
        add("sll ex", 0, 6'h00, 6'h00, 0, 4'd6, ex_o);
        add("sll wb", 0, 6'h00, 6'h00, 0, 4'd7, wb_o);
        // srl / sub / slt / and
        add("srl f",  0, 6'h00, 6'h02, 0, 4'd0, f_o);
        add("srl d",  0, 6'h00, 6'h02, 0, 4'd1, z_o);
        add("srl ex", 0, 6'h00, 6'h02, 0, 4'd6, mk(0,0,0,0,0, 2'b00,2'b10,1,2'b00,4'd6,0,2'b00,0));
        add("srl wb", 0, 6'h00, 6'h02, 0, 4'd7, mk(0,0,0,0,1, 2'b01,2'b10,1,2'b01,4'd6,0,2'b00,0));
        add("sub f",  0, 6'h00, 6'h22, 0, 4'd0, f_o);
        add("sub d",  0, 6'h00, 6'h22, 0, 4'd1, z_o);
        add("sub ex", 0, 6'h00, 6'h22, 0, 4'd6, mk(0,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd1,0,2'b00,0));
        add("sub wb", 0, 6'h00, 6'h22, 0, 4'd7, mk(0,0,0,0,1, 2'b01,2'b00,0,2'b01,4'd1,0,2'b00,0));
        add("slt f",  0, 6'h00, 6'h2a, 0, 4'd0, f_o);
        add("slt d",  0, 6'h00, 6'h2a, 0, 4'd1, z_o);
        add("slt ex", 0, 6'h00, 6'h2a, 0, 4'd6, mk(0,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd4,0,2'b00,0));
        add("slt wb", 0, 6'h00, 6'h2a, 0, 4'd7, mk(0,0,0,0,1, 2'b01,2'b00,0,2'b01,4'd4,0,2'b00,0));
        // addi / ori / lui
        add("addi f",  0, 6'h08, 6'h3f, 0, 4'd0, f_o);
        add("addi d",  0, 6'h08, 6'h3f, 0, 4'd1, z_o);
        add("addi ex", 0, 6'h08, 6'h3f, 0, 4'd6, mk(0,0,0,0,0, 2'b00,2'b01,0,2'b00,4'd0,1,2'b00,0));
        add("addi wb", 0, 6'h08, 6'h3f, 0, 4'd7, mk(0,0,0,0,1, 2'b00,2'b01,0,2'b01,4'd0,1,2'b00,0));
        add("ori f",   0, 6'h0d, 6'h00, 0, 4'd0, f_o);
        add("ori d",   0, 6'h0d, 6'h00, 0, 4'd1, z_o);
        add("ori ex",  0, 6'h0d, 6'h00, 0, 4'd6, mk(0,0,0,0,0, 2'b00,2'b01,0,2'b00,4'd3,0,2'b00,0));
        add("ori wb",  0, 6'h0d, 6'h00, 0, 4'd7, mk(0,0,0,0,1, 2'b00,2'b01,0,2'b01,4'd3,0,2'b00,0));
        add("lui f",   0, 6'h0f, 6'h00, 0, 4'd0, f_o);
        add("lui d",   0, 6'h0f, 6'h00, 0, 4'd1, z_o);
        add("lui ex",  0, 6'h0f, 6'h00, 0, 4'd6, mk(0,0,0,0,0, 2'b00,2'b01,0,2'b00,4'd7,0,2'b00,0));
        add("lui wb",  0, 6'h0f, 6'h00, 0, 4'd7, mk(0,0,0,0,1, 2'b00,2'b01,0,2'b01,4'd7,0,2'b00,0));
        // sw
        add("sw f",    0, 6'h2b, 6'h00, 0, 4'd0, f_o);
        add("sw d",    0, 6'h2b, 6'h00, 0, 4'd1, z_o);
        add("sw madr", 0, 6'h2b, 6'h00, 0, 4'd2, madr_o);
        add("sw mwr",  0, 6'h2b, 6'h00, 0, 4'd5, mk(0,1,0,1,0, 2'b00,2'b01,0,2'b00,4'd0,1,2'b00,0));
        // reset arriving in S_MWR, held two cycles
        add("rsw f",    0, 6'h2b, 6'h00, 0, 4'd0, f_o);
        add("rsw d",    0, 6'h2b, 6'h00, 0, 4'd1, z_o);
        add("rsw madr", 0, 6'h2b, 6'h00, 0, 4'd2, madr_o);
        add("rsw rst1", 1, 6'h2b, 6'h00, 0, 4'd5, z_o);
        add("rsw rst2", 1, 6'h2b, 6'h00, 0, 4'd0, z_o);
        // branches
        add("beq1 f",  0, 6'h04, 6'h00, 1, 4'd0, f_o);
        add("beq1 d",  0, 6'h04, 6'h00, 1, 4'd1, z_o);
        add("beq1 br", 0, 6'h04, 6'h00, 1, 4'd8, mk(1,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd1,0,2'b01,0));
        add("beq0 f",  0, 6'h04, 6'h00, 0, 4'd0, f_o);
        add("beq0 d",  0, 6'h04, 6'h00, 0, 4'd1, z_o);
        add("beq0 br", 0, 6'h04, 6'h00, 0, 4'd8, mk(0,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd1,0,2'b01,0));
        add("bne1 f",  0, 6'h05, 6'h00, 1, 4'd0, f_o);
        add("bne1 d",  0, 6'h05, 6'h00, 1, 4'd1, z_o);
        add("bne1 br", 0, 6'h05, 6'h00, 1, 4'd8, mk(0,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd1,0,2'b01,0));
        add("bne0 f",  0, 6'h05, 6'h00, 0, 4'd0, f_o);
        add("bne0 d",  0, 6'h05, 6'h00, 0, 4'd1, z_o);
        add("bne0 br", 0, 6'h05, 6'h00, 0, 4'd8, mk(1,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd1,0,2'b01,0));
        // jumps
        add("j f",     0, 6'h02, 6'h00, 0, 4'd0, f_o);
        add("j d",     0, 6'h02, 6'h00, 0, 4'd1, z_o);
        add("j jmp",   0, 6'h02, 6'h00, 0, 4'd9, mk(1,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd0,0,2'b10,0));
        add("jal f",   0, 6'h03, 6'h00, 0, 4'd0, f_o);
        add("jal d",   0, 6'h03, 6'h00, 0, 4'd1, z_o);
        add("jal jmp", 0, 6'h03, 6'h00, 0, 4'd9, mk(1,0,0,0,1, 2'b10,2'b00,0,2'b10,4'd0,0,2'b10,0));
        add("jr f",    0, 6'h00, 6'h08, 0, 4'd0, f_o);
        add("jr d",    0, 6'h00, 6'h08, 0, 4'd1, z_o);
        add("jr jmp",  0, 6'h00, 6'h08, 0, 4'd9, mk(1,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd0,0,2'b11,0));
        // illegal opcode and funct
        add("ilop f",  0, 6'h3f, 6'h00, 0, 4'd0, f_o);
        add("ilop d",  0, 6'h3f, 6'h00, 0, 4'd1, mk(0,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd0,0,2'b00,1));
        add("ilfn f",  0, 6'h00, 6'h3f, 0, 4'd0, f_o);
        add("ilfn d",  0, 6'h00, 6'h3f, 0, 4'd1, mk(0,0,0,0,0, 2'b00,2'b00,0,2'b00,4'd0,0,2'b00,1));

        rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; Op = vecs[i].op; Funct = vecs[i].funct; Zero = vecs[i].zero;
            @(negedge clk);
            check({vecs[i].name, " state"}, 32'(State), 32'(vecs[i].st));
            check({vecs[i].name, " outs"}, 32'(act), 32'(vecs[i].o));
            @(posedge clk); #1;
        end

        // Reset landing in S_MWB must suppress the register write.
        rst = 1'b0; Op = 6'h23; Funct = '0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check("mwb rst state", 32'(State), 32'd4);
        check("mwb rst regwrite", 32'(RegWrite), 32'd0);
        @(posedge clk); #1;
        check("mwb rst after", 32'(State), 32'd0);
        rst = 1'b0;

        // Cycles per instruction, register/memory writes, PC writes (Zero held 1).
        run_instr("lw",   6'h23, 6'h00, 5, 1, 1);
        run_instr("add",  6'h00, 6'h20, 4, 1, 1);
        run_instr("sw",   6'h2b, 6'h00, 4, 1, 1);
        run_instr("lui",  6'h0f, 6'h00, 4, 1, 1);
        run_instr("beq",  6'h04, 6'h00, 3, 0, 2);
        run_instr("bne",  6'h05, 6'h00, 3, 0, 1);
        run_instr("jal",  6'h03, 6'h00, 3, 1, 2);
        run_instr("jr",   6'h00, 6'h08, 3, 0, 2);
        run_instr("ill",  6'h3f, 6'h00, 2, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
